// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the load/store unit.
// Holds the FSM state encoding, RV32 funct3 codes and the access legality check.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        RESP = 2'b11
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // An access is an error if the funct3 code is not legal for its direction,
    // or if a halfword/word access is not naturally aligned.
    function automatic logic access_err(input logic       we,
                                        input logic [2:0] funct3,
                                        input logic [1:0] addr_lo);
        logic legal;
        logic misaligned;
        case (funct3)
            F3_B, F3_H, F3_W: legal = 1'b1;
            F3_BU, F3_HU:     legal = ~we;
            default:          legal = 1'b0;
        endcase
        case (funct3[1:0])
            2'b01:   misaligned = addr_lo[0];
            2'b10:   misaligned = (addr_lo != 2'b00);
            default: misaligned = 1'b0;
        endcase
        return ~legal | misaligned;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Purely combinational byte-lane logic: store mask/shift and load shift/extend.
// Byte offset comes from the low address bits; size and signedness from funct3.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_raw,
    output logic [3:0]  mask,
    output logic [31:0] wdata_shifted,
    output logic [31:0] rdata_ext
);

    logic [4:0]  shamt;
    logic [3:0]  base_mask;
    logic [31:0] rdata_shifted;

    always_comb begin
        shamt = {addr_lo, 3'b000};
        case (funct3[1:0])
            2'b00:   base_mask = 4'b0001;
            2'b01:   base_mask = 4'b0011;
            default: base_mask = 4'b1111;
        endcase
        mask          = base_mask << addr_lo;
        wdata_shifted = wdata << shamt;
        rdata_shifted = rdata_raw >> shamt;
        case (funct3)
            F3_B:    rdata_ext = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
            F3_H:    rdata_ext = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
            F3_BU:   rdata_ext = {24'h0, rdata_shifted[7:0]};
            F3_HU:   rdata_ext = {16'h0, rdata_shifted[15:0]};
            default: rdata_ext = rdata_shifted;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Single-outstanding load/store unit bridging a core request port to a simple
// memory initiator; one request is taken in IDLE and answered before the next.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_mask,
    input  logic [31:0] mem_rdata
);

    state_t      state;
    state_t      state_next;
    logic [3:0]  cnt;
    logic [31:0] addr_q;
    logic [2:0]  funct3_q;
    logic        we_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic        err_now;
    logic        accept;
    logic [3:0]  align_mask;
    logic [31:0] align_wdata;
    logic [31:0] align_rdata;

    assign err_now = access_err(req_we, req_funct3, req_addr[1:0]);
    assign accept  = (state == IDLE) && req_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (err_now)     state_next = RESP;
                    else if (req_we) state_next = WR;
                    else             state_next = RD;
                end
            end
            RD:      if (cnt == 4'd0) state_next = RESP;
            WR:      state_next = RESP;
            RESP:    if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The counter is preloaded so that mem_read spans MEM_LAT cycles and the
    // memory word is captured on the edge that ends the final RD cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= 4'd0;
            addr_q   <= 32'h0;
            funct3_q <= 3'b000;
            we_q     <= 1'b0;
            wdata_q  <= 32'h0;
            err_q    <= 1'b0;
            rdata_q  <= 32'h0;
        end else if (accept) begin
            cnt      <= 4'(MEM_LAT - 1);
            addr_q   <= req_addr;
            funct3_q <= req_funct3;
            we_q     <= req_we;
            wdata_q  <= req_wdata;
            err_q    <= err_now;
        end else if (state == RD) begin
            if (cnt == 4'd0) begin
                rdata_q <= mem_rdata;
            end else begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    lsu_align u_align (
        .funct3        (funct3_q),
        .addr_lo       (addr_q[1:0]),
        .wdata         (wdata_q),
        .rdata_raw     (rdata_q),
        .mask          (align_mask),
        .wdata_shifted (align_wdata),
        .rdata_ext     (align_rdata)
    );

    always_comb begin
        req_ready  = (state == IDLE) && rst;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = 32'h0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = 32'h0;
        mem_wdata  = 32'h0;
        mem_mask   = 4'b0000;
        case (state)
            RD: begin
                mem_read = 1'b1;
                mem_addr = {addr_q[31:2], 2'b00};
                mem_mask = align_mask;
            end
            WR: begin
                mem_write = 1'b1;
                mem_addr  = {addr_q[31:2], 2'b00};
                mem_mask  = align_mask;
                mem_wdata = align_wdata;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_rdata = (!we_q && !err_q) ? align_rdata : 32'h0;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter MEM_LAT, default 1, meaning cycles mem_read is held before read data is sampled (legal 1..15).
REQ-002 SHALL have port clk  input  1  the only clock.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid  input  1  core access request.
REQ-005 SHALL have port req_ready  output  1  lsu accepts request.
REQ-006 SHALL have port req_we  input  1  1=store, 0=load.
REQ-007 SHALL have port req_funct3  input  3  RV32 size/sign code.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data, right-justified.
REQ-010 SHALL have port resp_valid  output  1  response available.
REQ-011 SHALL have port resp_ready  input  1  core consumes response.
REQ-012 SHALL have port resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-013 SHALL have port resp_err  output  1  misaligned or illegal funct3.
REQ-014 SHALL have ports mem_read, mem_write (output 1), mem_addr, mem_wdata (output 32), mem_mask (output 4), mem_rdata (input 32, combinational from memory), forming the memory-initiator side.

Function
REQ-015 SHALL implement FSM IDLE, RD, WR, RESP; req_ready = (state==IDLE).
REQ-016 SHALL accept on req_valid&&req_ready and register addr, funct3, we, wdata.
REQ-017 SHALL decode loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW; any other code SHALL be an error.
REQ-018 SHALL flag misalignment: halfword with addr[0]=1, word with addr[1:0]!=0.
REQ-019 SHALL on error go IDLE->RESP directly, resp_err=1, resp_rdata=0, never asserting mem_read or mem_write.
REQ-020 SHALL drive mem_addr = {addr[31:2],2'b00} during RD and WR, 0 otherwise.
REQ-021 SHALL in WR assert mem_write for exactly one cycle with mem_mask = size mask (0001/0011/1111) << addr[1:0] and mem_wdata = wdata << 8*addr[1:0], then go RESP.
REQ-022 SHALL in RD hold mem_read high for MEM_LAT cycles via a down-counter, capture mem_rdata on the last RD cycle's edge, then go RESP.
REQ-023 SHALL form resp_rdata by shifting captured data right 8*addr[1:0] and sign- (LB/LH) or zero- (LBU/LHU) extending; LW unmodified.
REQ-024 SHALL hold resp_valid, resp_rdata, resp_err stable in RESP until resp_ready; leave RESP to IDLE on that edge.
REQ-025 SHALL give latency accept-to-resp_valid: error 1 cycle, store 2, load MEM_LAT+1.
REQ-026 SHALL keep mem_read, mem_write, mem_mask 0 outside RD/WR; never assert both together.
REQ-027 SHALL ignore req_valid outside IDLE (no queuing); back-to-back requests SHALL be accepted the cycle after RESP handshake.

Reset
REQ-028 SHALL on rst low immediately force state IDLE, counter 0, and all outputs 0 except req_ready, which SHALL be 0 while rst low and 1 the first cycle after release.
REQ-029 SHALL on reset mid-RD/WR drop the access (mem_write deasserted asynchronously, no response produced).

Structure
REQ-030 SHALL place funct3 constants and state enum in shared package lsu_pkg.
REQ-031 SHALL put mask/shift/extend logic in one combinational sub-module lsu_align; FSM, counter, registers stay in lsu.
REQ-032 SHALL be synthesizable, no DPI calls inside lsu.

Verification
REQ-033 SB addr 0x80000003 data 0x000000AB -> one mem_write cycle, mem_addr 0x80000000, mask 1000, wdata 0xAB000000, resp_valid 2 cycles after accept.
REQ-034 LH addr 0x80000002, memory word 0x8001_1234 -> resp_rdata 0xFFFF8001; LHU same -> 0x00008001; MEM_LAT=3 gives resp_valid 4 cycles after accept.
REQ-035 LW addr 0x80000006 -> resp_err=1, resp_rdata 0, mem_read/mem_write never high, resp_valid 1 cycle after accept.
REQ-036 funct3=011 load -> resp_err=1; resp_ready low 5 cycles -> outputs stable, req_ready 0 throughout.
REQ-037 rst low during WR cycle -> mem_write falls without clock edge, no resp_valid; first request after release accepted normally.
REQ-038 Two back-to-back SW/LW to 0x80000010 with resp_ready=1 -> load returns stored 0xDEADBEEF.
